// File: rtl/canny_pkg.sv
// Shared types and defaults for the edge-detector output stage.
//  scan_mode_t : pixel visiting order within a frame
//  out_mode_t  : what gets written to SRAM for each pixel
//  wr_state_t  : write sequencer FSM states
package canny_pkg;

  localparam int unsigned IMG_W_DEF = 512;
  localparam int unsigned IMG_H_DEF = 512;

  typedef enum logic { SCAN_RASTER = 1'b0, SCAN_SERP  = 1'b1 } scan_mode_t;
  typedef enum logic { OUT_PASS    = 1'b0, OUT_BINARY = 1'b1 } out_mode_t;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_WRITE = 2'd1,
    WR_DONE  = 2'd2
  } wr_state_t;

endpackage

// File: rtl/xy_scan_counter.sv
// Image position counter for the SRAM write sequencer.
//  clk, n_rst : clock, async active-low reset
//  clr        : restart at (0,0) heading right
//  adv        : step to the next pixel of the scan
//  serp       : 0 raster, 1 serpentine (boustrophedon) order
//  x, y       : current pixel position
//  last       : current pixel is the final one of the frame
module xy_scan_counter #(
  parameter int unsigned IMG_W = 512,
  parameter int unsigned IMG_H = 512,
  parameter int unsigned XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  parameter int unsigned YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clr,
  input  logic          adv,
  input  logic          serp,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          dir_q, dir_d;  // 0 moving right, 1 moving left

  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    dir_d = dir_q;
    if (clr) begin
      x_d   = '0;
      y_d   = '0;
      dir_d = 1'b0;
    end else if (adv) begin
      if (!serp) begin
        if (x_q == X_MAX) begin
          x_d = '0;
          y_d = y_q + YW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end
      end else if (!dir_q) begin
        // Serpentine row turn: x stays at the row end, next row starts there.
        if (x_q == X_MAX) begin
          y_d   = y_q + YW'(1);
          dir_d = 1'b1;
        end else begin
          x_d = x_q + XW'(1);
        end
      end else begin
        if (x_q == '0) begin
          y_d   = y_q + YW'(1);
          dir_d = 1'b0;
        end else begin
          x_d = x_q - XW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x_q   <= '0;
      y_q   <= '0;
      dir_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      dir_q <= dir_d;
    end
  end

  // dir stays 0 in raster mode, so the row end is always X_MAX there.
  assign last = (y_q == Y_MAX) && (dir_q ? (x_q == '0) : (x_q == X_MAX));
  assign x    = x_q;
  assign y    = y_q;

endmodule

// File: rtl/sram_write_sequencer.sv
// Final edge-detector stage: takes one result pixel per valid/ready handshake
// and writes it to SRAM at BASE_ADDR + y*IMG_W + x, one cycle after accept.
//  clk, n_rst            : clock, async active-low reset
//  start                 : begin a frame (only looked at in IDLE)
//  scan_mode, out_mode   : scan order / data select, latched with start
//  in_valid / in_ready   : upstream pixel handshake
//  hysteresis_result     : edge bit, replicated across the word in binary mode
//  pixel_data            : raw pixel for pass-through mode
//  sram_write_enable     : one-cycle write strobe
//  write_address         : SRAM address, valid with strobe
//  output_data           : SRAM data, valid with strobe
//  busy                  : frame in progress (WRITE or DONE)
//  frame_done            : pulse coincident with the final write strobe
module sram_write_sequencer
  import canny_pkg::*;
#(
  parameter int unsigned IMG_W     = IMG_W_DEF,
  parameter int unsigned IMG_H     = IMG_H_DEF,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              scan_mode,
  input  logic              out_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              hysteresis_result,
  input  logic [DATA_W-1:0] pixel_data,
  output logic              sram_write_enable,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] output_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  wr_state_t         state_q, state_d;
  scan_mode_t        scan_q, scan_d;
  out_mode_t         omode_q, omode_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          last;
  logic          accept;
  logic          frame_start;

  // in_ready depends only on registered state, never on in_valid.
  assign in_ready    = (state_q == WR_WRITE);
  assign accept      = in_valid & in_ready;
  assign frame_start = (state_q == WR_IDLE) & start;

  xy_scan_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .XW    (XW),
    .YW    (YW)
  ) u_xy (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (frame_start),
    .adv   (accept),
    .serp  (scan_q == SCAN_SERP),
    .x     (x),
    .y     (y),
    .last  (last)
  );

  always_comb begin
    state_d = state_q;
    scan_d  = scan_q;
    omode_d = omode_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      WR_IDLE: begin
        if (start) begin
          state_d = WR_WRITE;
          scan_d  = scan_mode_t'(scan_mode);
          omode_d = out_mode_t'(out_mode);
        end
      end
      WR_WRITE: begin
        if (accept) begin
          we_d   = 1'b1;
          // Full ADDR_W arithmetic so large frames never wrap early.
          addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);
          data_d = (omode_q == OUT_BINARY) ? {DATA_W{hysteresis_result}} : pixel_data;
          if (last) begin
            state_d = WR_DONE;
            done_d  = 1'b1;  // lands with the final strobe
          end
        end
      end
      WR_DONE: state_d = WR_IDLE;
      default: state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= WR_IDLE;
      scan_q  <= SCAN_RASTER;
      omode_q <= OUT_PASS;
      we_q    <= 1'b0;
      addr_q  <= ADDR_W'(BASE_ADDR);
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
      omode_q <= omode_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign sram_write_enable = we_q;
  assign write_address     = addr_q;
  assign output_data       = data_q;
  assign busy              = (state_q != WR_IDLE);
  assign frame_done        = done_q;

endmodule
